// File: rtl/unified_mem_arbiter.sv
// Two-port (fetch read-only, data read/write) arbiter sharing one fixed-latency backing memory.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module unified_mem_arbiter #(
  parameter int unsigned LAT          = 2,
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic [WIDTH-1:0] if_rdata,
  output logic             if_done,
  output logic             if_stall,
  input  logic             d_req,
  input  logic             d_wr,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_done,
  output logic             d_stall,
  output logic             m_en,
  output logic             m_wr,
  output logic [WIDTH-1:0] m_addr,
  output logic [WIDTH-1:0] m_wdata,
  input  logic [WIDTH-1:0] m_rdata
);

  if (LAT < 1 || LAT > 15) begin : g_bad_lat
    $error("LAT must be in 1..15");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..7");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             wr_q, wr_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic             pick_data;

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0]       starve_q, starve_d;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    pick_data  = d_req;
`ifdef ARB_STARVE_GUARD_EN
    starve_d   = starve_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
`ifdef ARB_STARVE_GUARD_EN
          // Fetch takes one tie after losing STARVE_LIMIT grants in a row.
          if (if_req && d_req && (32'(starve_q) >= STARVE_LIMIT)) begin
            pick_data = 1'b0;
          end
          if (!pick_data) begin
            starve_d = '0;
          end else if (if_req) begin
            starve_d = starve_q + 3'd1;
          end
`endif
          owner_d = pick_data;
          addr_d  = pick_data ? d_addr : if_addr;
          wr_d    = pick_data & d_wr;
          wdata_d = pick_data ? d_wdata : wdata_q;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = 4'(LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (!wr_q) begin
            if (owner_q) d_rdata_d  = m_rdata;
            else         if_rdata_d = m_rdata;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end
`endif

  assign m_en     = (state_q == ISSUE);
  assign m_wr     = m_en & wr_q;
  assign m_addr   = addr_q;
  assign m_wdata  = wdata_q;
  assign if_done  = (state_q == RESP) & ~owner_q;
  assign d_done   = (state_q == RESP) & owner_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_stall = if_req & ~if_done;
  assign d_stall  = d_req & ~d_done;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench: instance A (LAT=2) and instance B (LAT=1), each with a behavioural backing memory.
module tb_unified_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Instance A, LAT=2
  logic        a_if_req = 0, a_d_req = 0, a_d_wr = 0;
  logic [15:0] a_if_addr = 0, a_d_addr = 0, a_d_wdata = 0;
  logic [15:0] a_if_rdata, a_d_rdata, a_m_addr, a_m_wdata, a_m_rdata;
  logic        a_if_done, a_if_stall, a_d_done, a_d_stall, a_m_en, a_m_wr;

  unified_mem_arbiter #(.LAT(2), .WIDTH(16), .STARVE_LIMIT(4)) u_a (
    .clk(clk), .rst(rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata),
    .if_done(a_if_done), .if_stall(a_if_stall),
    .d_req(a_d_req), .d_wr(a_d_wr), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_rdata(a_d_rdata), .d_done(a_d_done), .d_stall(a_d_stall),
    .m_en(a_m_en), .m_wr(a_m_wr), .m_addr(a_m_addr), .m_wdata(a_m_wdata),
    .m_rdata(a_m_rdata)
  );

  // Instance B, LAT=1
  logic        b_if_req = 0, b_d_req = 0, b_d_wr = 0;
  logic [15:0] b_if_addr = 0, b_d_addr = 0, b_d_wdata = 0;
  logic [15:0] b_if_rdata, b_d_rdata, b_m_addr, b_m_wdata, b_m_rdata;
  logic        b_if_done, b_if_stall, b_d_done, b_d_stall, b_m_en, b_m_wr;

  unified_mem_arbiter #(.LAT(1), .WIDTH(16), .STARVE_LIMIT(4)) u_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata),
    .if_done(b_if_done), .if_stall(b_if_stall),
    .d_req(b_d_req), .d_wr(b_d_wr), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_done(b_d_done), .d_stall(b_d_stall),
    .m_en(b_m_en), .m_wr(b_m_wr), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
    .m_rdata(b_m_rdata)
  );

  // Backing memories: default content addr^A5A5, mem[0x10]=BEEF; read data appears LAT cycles after m_en.
  logic [15:0] mem_a [512];
  logic [15:0] mem_b [512];
  logic [15:0] pipe_a [2];
  logic [15:0] pipe_b;

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem_a[i] = 16'(i) ^ 16'hA5A5;
      mem_b[i] = 16'(i) ^ 16'hA5A5;
    end
    mem_a[16'h0010] = 16'hBEEF;
    mem_b[16'h0010] = 16'hBEEF;
    pipe_a[0] = '0;
    pipe_a[1] = '0;
    pipe_b    = '0;
  end

  always @(posedge clk) begin
    pipe_a[1] <= pipe_a[0];
    pipe_a[0] <= 16'hDEAD;
    if (a_m_en) begin
      if (a_m_wr) mem_a[a_m_addr[8:0]] <= a_m_wdata;
      pipe_a[0] <= mem_a[a_m_addr[8:0]];
    end
    pipe_b <= 16'hDEAD;
    if (b_m_en) begin
      if (b_m_wr) mem_b[b_m_addr[8:0]] <= b_m_wdata;
      pipe_b <= mem_b[b_m_addr[8:0]];
    end
  end
  assign a_m_rdata = pipe_a[1];
  assign b_m_rdata = pipe_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one cycle; checks happen 2 time units after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [5:0] grant_seq;
  int unsigned k;
  int unsigned n_ifdone;

  initial begin
    rst = 1'b0;
    #12;
    check("rst_m_en", 32'(a_m_en), 0);
    check("rst_if_done", 32'(a_if_done), 0);
    check("rst_d_done", 32'(a_d_done), 0);
    check("rst_if_rdata", 32'(a_if_rdata), 0);
    check("rst_d_rdata", 32'(a_d_rdata), 0);
    rst = 1'b1;
    cyc();

    // Fetch read, LAT=2
    a_if_req = 1; a_if_addr = 16'h0010;
    #1;
    check("fr_c0_stall", 32'(a_if_stall), 1);
    check("fr_c0_m_en", 32'(a_m_en), 0);
    cyc();
    check("fr_c1_m_en", 32'(a_m_en), 1);
    check("fr_c1_m_addr", 32'(a_m_addr), 32'h0010);
    check("fr_c1_m_wr", 32'(a_m_wr), 0);
    check("fr_c1_stall", 32'(a_if_stall), 1);
    cyc();
    check("fr_c2_m_en", 32'(a_m_en), 0);
    check("fr_c2_stall", 32'(a_if_stall), 1);
    cyc();
    check("fr_c3_stall", 32'(a_if_stall), 1);
    check("fr_c3_done", 32'(a_if_done), 0);
    cyc();
    check("fr_c4_done", 32'(a_if_done), 1);
    check("fr_c4_rdata", 32'(a_if_rdata), 32'hBEEF);
    check("fr_c4_stall", 32'(a_if_stall), 0);
    check("fr_c4_d_done", 32'(a_d_done), 0);
    a_if_req = 0;
    cyc();
    check("fr_c5_done", 32'(a_if_done), 0);
    check("fr_c5_rdata_hold", 32'(a_if_rdata), 32'hBEEF);

    // Simultaneous requests: data read 0x0002 first, then fetch 0x0010
    a_if_req = 1; a_if_addr = 16'h0010;
    a_d_req = 1; a_d_wr = 0; a_d_addr = 16'h0002;
    for (int c = 0; c <= 9; c++) begin
      #1;
      if (c <= 8) check($sformatf("sim_c%0d_if_stall", c), 32'(a_if_stall), 1);
      if (c == 1) begin
        check("sim_c1_m_en", 32'(a_m_en), 1);
        check("sim_c1_m_addr", 32'(a_m_addr), 32'h0002);
      end
      if (c == 4) begin
        check("sim_c4_d_done", 32'(a_d_done), 1);
        check("sim_c4_d_rdata", 32'(a_d_rdata), 32'hA5A7);
        check("sim_c4_if_done", 32'(a_if_done), 0);
        a_d_req = 0;
      end
      if (c == 6) begin
        check("sim_c6_m_en", 32'(a_m_en), 1);
        check("sim_c6_m_addr", 32'(a_m_addr), 32'h0010);
      end
      if (c == 8) check("sim_c8_if_done", 32'(a_if_done), 0);
      if (c == 9) begin
        check("sim_c9_if_done", 32'(a_if_done), 1);
        check("sim_c9_if_rdata", 32'(a_if_rdata), 32'hBEEF);
        check("sim_c9_d_done", 32'(a_d_done), 0);
        a_if_req = 0;
      end
      cyc();
    end

    // Data write 0x1234 -> 0x0100
    a_d_req = 1; a_d_wr = 1; a_d_addr = 16'h0100; a_d_wdata = 16'h1234;
    for (int c = 0; c <= 4; c++) begin
      #1;
      if (c == 1) begin
        check("wr_c1_m_en", 32'(a_m_en), 1);
        check("wr_c1_m_wr", 32'(a_m_wr), 1);
        check("wr_c1_m_addr", 32'(a_m_addr), 32'h0100);
        check("wr_c1_m_wdata", 32'(a_m_wdata), 32'h1234);
      end
      if (c == 2 || c == 3) begin
        check($sformatf("wr_c%0d_m_en", c), 32'(a_m_en), 0);
        check($sformatf("wr_c%0d_m_wr", c), 32'(a_m_wr), 0);
      end
      if (c == 3) check("wr_c3_d_done", 32'(a_d_done), 0);
      if (c == 4) begin
        check("wr_c4_d_done", 32'(a_d_done), 1);
        check("wr_c4_d_rdata_hold", 32'(a_d_rdata), 32'hA5A7);
        a_d_req = 0; a_d_wr = 0;
      end
      cyc();
    end

    // Reset during WAIT of a fetch read
    a_if_req = 1; a_if_addr = 16'h0002;
    cyc(); cyc();
    #1;
    rst = 1'b0;
    a_if_req = 0;
    #1;
    check("mid_rst_m_en", 32'(a_m_en), 0);
    check("mid_rst_if_done", 32'(a_if_done), 0);
    check("mid_rst_d_done", 32'(a_d_done), 0);
    check("mid_rst_if_rdata", 32'(a_if_rdata), 0);
    check("mid_rst_d_rdata", 32'(a_d_rdata), 0);
    cyc();
    rst = 1'b1;
    n_ifdone = 0;
    for (int c = 0; c < 6; c++) begin
      cyc();
      if (a_if_done || a_d_done || a_m_en) n_ifdone++;
    end
    check("post_rst_quiet", n_ifdone, 0);
    a_if_req = 1; a_if_addr = 16'h0010;
    for (int c = 0; c < 4; c++) cyc();
    #1;
    check("post_rst_if_done", 32'(a_if_done), 1);
    check("post_rst_if_rdata", 32'(a_if_rdata), 32'hBEEF);
    a_if_req = 0;
    cyc();

    // Read back the earlier write
    a_d_req = 1; a_d_wr = 0; a_d_addr = 16'h0100;
    for (int c = 0; c < 4; c++) cyc();
    #1;
    check("rb_d_done", 32'(a_d_done), 1);
    check("rb_d_rdata", 32'(a_d_rdata), 32'h1234);
    a_d_req = 0;
    cyc();

    // Back-to-back data reads on B (LAT=1)
    b_d_req = 1; b_d_wr = 0; b_d_addr = 16'h0002;
    for (int c = 0; c <= 7; c++) begin
      #1;
      check($sformatf("b2b_c%0d_m_en", c), 32'(b_m_en), (c == 1 || c == 5) ? 1 : 0);
      check($sformatf("b2b_c%0d_d_done", c), 32'(b_d_done), (c == 3 || c == 7) ? 1 : 0);
      if (c == 1) check("b2b_c1_m_addr", 32'(b_m_addr), 32'h0002);
      if (c == 5) check("b2b_c5_m_addr", 32'(b_m_addr), 32'h0004);
      if (c == 3) begin
        check("b2b_c3_d_rdata", 32'(b_d_rdata), 32'hA5A7);
        b_d_addr = 16'h0004;
      end
      if (c == 7) begin
        check("b2b_c7_d_rdata", 32'(b_d_rdata), 32'hA5A1);
        b_d_req = 0;
      end
      cyc();
    end

    // Fetch held, data held: record which port completes each of six transactions
    b_if_req = 1; b_if_addr = 16'h0010;
    b_d_req = 1; b_d_addr = 16'h0002;
    grant_seq = '0;
    k = 0;
    for (int c = 0; c < 24; c++) begin
      #1;
      if ((b_if_done || b_d_done) && k < 6) begin
        grant_seq[k] = b_if_done;
        k++;
      end
      cyc();
    end
    check("starve_ndone", k, 6);
`ifdef ARB_STARVE_GUARD_EN
    check("starve_seq", 32'(grant_seq), 32'b010000);
`else
    check("starve_seq", 32'(grant_seq), 32'b000000);
`endif
    b_if_req = 0; b_d_req = 0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
